control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CW_W, default 31: control-word width; fixed field map per REQ-012.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_op  input  4  opcode: 0 NOP, 1 MOVI, 2 ADD, 3 ADDI, 4 XOR, 5 LSLI, 6 STUR, 7 LDUR; 8-15 illegal.
REQ-007 cmd_rd, cmd_rn, cmd_rm  input  5 each  destination/store-data, first source, second source register.
REQ-008 cmd_imm  input  64  immediate / address offset.
REQ-009 controlWord  output  31  registered datapath control word.
REQ-010 K  output  64  registered constant to datapath.
REQ-011 done  output  1  one-cycle pulse on last cycle of each legal instruction; retired  output  16  retired count; err  output  1  sticky illegal-opcode flag.

Function
REQ-012 Field map: [30:29] PS, [28:24] DA, [23:19] SA, [18:14] SB, [13:9] FS, [8] regW, [7] ramW, [6] EN_MEM, [5] EN_ALU, [4] EN_B, [3] EN_PC, [2] selB, [1] PCsel, [0] SL.
REQ-013 FS codes: PASS/OR 00100, ADD 01000, XOR 01100, LSL 10000.
REQ-014 NOP word: PS=00, DA=SA=SB=11111, FS=00000, EN_ALU=1, all other bits 0; K=0 with NOP.
REQ-015 States: IDLE, EXEC, MEM_A, MEM_B.
REQ-016 Handshake: transfer on rising edge with cmd_valid & cmd_ready; cmd_ready = !reset & (IDLE | EXEC | MEM_B).
REQ-017 Latency: controlWord/K reflect an accepted command in the cycle after acceptance.
REQ-018 Non-LDUR accept -> EXEC for one cycle; LDUR accept -> MEM_A then MEM_B.
REQ-019 From EXEC or MEM_B: accept -> next instruction's first state (back-to-back, no bubble); else -> IDLE with NOP word.
REQ-020 MOVI: DA=rd, SA=31, FS=PASS, selB=1, regW=1, EN_ALU=1, K=imm.
REQ-021 ADD/XOR: DA=rd, SA=rn, SB=rm, selB=0, regW=1, EN_ALU=1, K=0.
REQ-022 ADDI/LSLI: DA=rd, SA=rn, SB=31, selB=1, regW=1, EN_ALU=1, K=imm.
REQ-023 STUR: DA=31, SA=rn, SB=rd, FS=ADD, selB=1, ramW=1, EN_B=1, regW=0, EN_ALU=0, K=imm.
REQ-024 LDUR MEM_A: SA=rn, SB=31, FS=ADD, selB=1, EN_MEM=1, regW=0, EN_ALU=0, PS=00, K=imm; MEM_B: identical except regW=1, DA=rd, PS=01.
REQ-025 PS=01 only on last cycle of a legal instruction; PS=00 otherwise; PCsel, SL, EN_PC always 0.
REQ-026 done=1 and retired+1 (modulo 2^16, FFFF wraps to 0000) on last cycle of each legal instruction.
REQ-027 Illegal opcode: accepted, one EXEC cycle of NOP word, err set to 1 and held until reset, no done, retired unchanged.
REQ-028 Opcode 0 NOP: one EXEC cycle of NOP word with PS=01, counts as retired.

Reset
REQ-029 Reset cycle: state=IDLE, controlWord=NOP word, K=0, done=0, retired=0, err=0, cmd_ready=0.
REQ-030 Reset mid-operation (incl. MEM_A) abandons instruction: no done, no regW/ramW next cycle.

Structure
REQ-031 Shared package holds opcode constants, FS codes, field-position constants, NOP word, state enumeration.
REQ-032 Combinational sub-module control_word_encoder maps (op, phase, rd, rn, rm) to 31-bit word; FSM and output registers in control_sequencer.

Verification
REQ-033 Reset, then MOVI rd=5 imm=24 -> next cycle controlWord=01_00101_11111_11111_00100_10_0100_1_0_0, K=24, done=1, retired=1.
REQ-034 Back-to-back ADD rd=1 rn=5 rm=7, XOR rd=30 rn=1 rm=5, LSLI rd=17 rn=30 imm=2 -> three consecutive words (FS 01000/01100/10000, selB 0/0/1), cmd_ready never low, retired=3.
REQ-035 STUR rd=17 rn=7 imm=0 -> ramW=1, EN_B=1, regW=0, DA=11111, SB=10001, PS=01, one cycle.
REQ-036 LDUR rd=0 rn=7 imm=0 -> MEM_A: EN_MEM=1, regW=0, PS=00, cmd_ready=0; MEM_B: regW=1, DA=0, PS=01, done=1.
REQ-037 cmd_op=12 -> NOP word one cycle, err=1 persists, retired unchanged; then reset -> err=0.
REQ-038 Preload retired=FFFF via 65535 NOPs, one more NOP -> retired=0000; reset asserted during LDUR MEM_A -> NOP word next cycle, done=0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, FS codes, control-word field positions, NOP word and
// sequencer state encoding for the control sequencer.
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOVI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LSLI = 4'd5;
  localparam logic [3:0] OP_STUR = 4'd6;
  localparam logic [3:0] OP_LDUR = 4'd7;

  localparam logic [4:0] FS_PASS = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_LSL  = 5'b10000;

  localparam logic [4:0] XZR = 5'd31;

  localparam int PS_LSB   = 29;
  localparam int DA_LSB   = 24;
  localparam int SA_LSB   = 19;
  localparam int SB_LSB   = 14;
  localparam int FS_LSB   = 9;
  localparam int REGW_B   = 8;
  localparam int RAMW_B   = 7;
  localparam int EN_MEM_B = 6;
  localparam int EN_ALU_B = 5;
  localparam int EN_B_B   = 4;
  localparam int EN_PC_B  = 3;
  localparam int SELB_B   = 2;
  localparam int PCSEL_B  = 1;
  localparam int SL_B     = 0;

  localparam logic [30:0] NOP_WORD = {2'b00, XZR, XZR, XZR, 5'b00000, 9'b00_0100_000};

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MEM_A, ST_MEM_B} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic op_uses_imm(input logic [3:0] op);
    return (op == OP_MOVI) || (op == OP_ADDI) || (op == OP_LSLI) ||
           (op == OP_STUR) || (op == OP_LDUR);
  endfunction

endpackage

// File: rtl/control_sequencer_encoder.sv
// Maps (op, phase, rd, rn, rm) to the datapath control word; phase is the
// state the sequencer is entering. Also flags the last cycle of a legal op.
module control_word_encoder
  import control_sequencer_pkg::*;
#(
  parameter int CW_W = 31
) (
  input  logic [3:0]      op,
  input  state_t          phase,
  input  logic [4:0]      rd,
  input  logic [4:0]      rn,
  input  logic [4:0]      rm,
  output logic [CW_W-1:0] word,
  output logic            last
);

  logic [1:0] ps;
  logic [4:0] da, sa, sb, fs;
  logic       regw, ramw, en_mem, en_alu, en_b, selb;

  always_comb begin
    ps = 2'b00; da = XZR; sa = XZR; sb = XZR; fs = 5'b00000;
    regw = 1'b0; ramw = 1'b0; en_mem = 1'b0; en_alu = 1'b1; en_b = 1'b0; selb = 1'b0;
    last = 1'b0;
    // Idle and illegal opcodes fall through as the NOP word.
    if (phase != ST_IDLE && op_legal(op)) begin
      last = (phase != ST_MEM_A);
      case (op)
        OP_MOVI: begin da = rd; fs = FS_PASS; selb = 1'b1; regw = 1'b1; end
        OP_ADD:  begin da = rd; sa = rn; sb = rm; fs = FS_ADD; regw = 1'b1; end
        OP_XOR:  begin da = rd; sa = rn; sb = rm; fs = FS_XOR; regw = 1'b1; end
        OP_ADDI: begin da = rd; sa = rn; fs = FS_ADD; selb = 1'b1; regw = 1'b1; end
        OP_LSLI: begin da = rd; sa = rn; fs = FS_LSL; selb = 1'b1; regw = 1'b1; end
        OP_STUR: begin
          sa = rn; sb = rd; fs = FS_ADD; selb = 1'b1;
          ramw = 1'b1; en_b = 1'b1; en_alu = 1'b0;
        end
        OP_LDUR: begin
          sa = rn; fs = FS_ADD; selb = 1'b1; en_mem = 1'b1; en_alu = 1'b0;
          if (phase == ST_MEM_B) begin regw = 1'b1; da = rd; end
        end
        default: ;
      endcase
      if (last) ps = 2'b01;
    end

    word = '0;
    word[PS_LSB +: 2] = ps;
    word[DA_LSB +: 5] = da;
    word[SA_LSB +: 5] = sa;
    word[SB_LSB +: 5] = sb;
    word[FS_LSB +: 5] = fs;
    word[REGW_B]      = regw;
    word[RAMW_B]      = ramw;
    word[EN_MEM_B]    = en_mem;
    word[EN_ALU_B]    = en_alu;
    word[EN_B_B]      = en_b;
    word[SELB_B]      = selb;
  end

endmodule

// File: rtl/control_sequencer.sv
// Command sequencer: accepts one instruction per cycle (LDUR takes two) and
// emits a registered control word, constant, done pulse and retire count.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int CW_W = 31
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [4:0]      cmd_rd,
  input  logic [4:0]      cmd_rn,
  input  logic [4:0]      cmd_rm,
  input  logic [63:0]     cmd_imm,
  output logic [CW_W-1:0] controlWord,
  output logic [63:0]     K,
  output logic            done,
  output logic [15:0]     retired,
  output logic            err
);

  state_t          state, state_nxt;
  logic            accept;
  logic [3:0]      lat_op, enc_op;
  logic [4:0]      lat_rd, lat_rn, lat_rm, enc_rd, enc_rn, enc_rm;
  logic [63:0]     lat_imm, enc_imm, k_nxt;
  logic [CW_W-1:0] word_nxt;
  logic            last_nxt;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    cmd_ready = !reset && (state != ST_MEM_A);
    accept    = cmd_valid && cmd_ready;
    state_nxt = ST_IDLE;
    case (state)
      ST_MEM_A: state_nxt = ST_MEM_B;
      default:  if (accept) state_nxt = (cmd_op == OP_LDUR) ? ST_MEM_A : ST_EXEC;
    endcase
    // A fresh command drives the encoder directly; MEM_B reuses the latched LDUR.
    enc_op = lat_op; enc_rd = lat_rd; enc_rn = lat_rn; enc_rm = lat_rm; enc_imm = lat_imm;
    if (accept) begin
      enc_op = cmd_op; enc_rd = cmd_rd; enc_rn = cmd_rn; enc_rm = cmd_rm; enc_imm = cmd_imm;
    end
    k_nxt = (state_nxt != ST_IDLE && op_uses_imm(enc_op)) ? enc_imm : 64'd0;
  end

  control_word_encoder #(.CW_W(CW_W)) u_enc (
    .op    (enc_op),
    .phase (state_nxt),
    .rd    (enc_rd),
    .rn    (enc_rn),
    .rm    (enc_rm),
    .word  (word_nxt),
    .last  (last_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      controlWord <= NOP_WORD;
      K           <= 64'd0;
      done        <= 1'b0;
      retired     <= 16'd0;
      err         <= 1'b0;
      lat_op      <= OP_NOP;
      lat_rd      <= 5'd0;
      lat_rn      <= 5'd0;
      lat_rm      <= 5'd0;
      lat_imm     <= 64'd0;
    end else begin
      controlWord <= word_nxt;
      K           <= k_nxt;
      done        <= last_nxt;
      if (last_nxt) retired <= retired + 16'd1;
      if (accept && !op_legal(cmd_op)) err <= 1'b1;
      if (accept) begin
        lat_op  <= cmd_op;
        lat_rd  <= cmd_rd;
        lat_rn  <= cmd_rn;
        lat_rm  <= cmd_rm;
        lat_imm <= cmd_imm;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed control words.
module tb_control_sequencer;

  logic        clock, reset, cmd_valid, cmd_ready, done, err;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [63:0] cmd_imm, K;
  logic [30:0] controlWord;
  logic [15:0] retired;

  int n_chk, n_err;

  localparam logic [30:0] NOPW  = 31'b00_11111_11111_11111_00000_00_0100_0_0_0;
  localparam logic [30:0] NOPR  = 31'b01_11111_11111_11111_00000_00_0100_0_0_0;
  localparam logic [30:0] MOVIW = 31'b01_00101_11111_11111_00100_10_0100_1_0_0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .controlWord(controlWord), .K(K), .done(done),
    .retired(retired), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] mk(input logic [1:0] ps, input logic [4:0] da,
      input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] fs, input logic [8:0] ctl);
    return {ps, da, sa, sb, fs, ctl};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
      input logic [4:0] rm, input logic [63:0] imm);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
    #1 chk("ready_at_issue", cmd_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic go_idle();
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = 4'd0;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0;
    cmd_rd = 5'd0; cmd_rn = 5'd0; cmd_rm = 5'd0; cmd_imm = 64'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cw", controlWord, NOPW);
    chk("rst_k", K, 64'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // MOVI rd=5 imm=24
    drive(4'd1, 5'd5, 5'd0, 5'd0, 64'd24);
    chk("movi_cw", controlWord, MOVIW);
    chk("movi_k", K, 64'd24);
    chk("movi_done", done, 1'b1);
    chk("movi_retired", retired, 16'd1);
    go_idle();
    chk("idle_cw", controlWord, NOPW);
    chk("idle_done", done, 1'b0);
    chk("idle_k", K, 64'd0);

    // Back-to-back ALU ops
    do_reset();
    drive(4'd2, 5'd1, 5'd5, 5'd7, 64'd99);
    chk("add_cw", controlWord, mk(2'b01, 5'd1, 5'd5, 5'd7, 5'b01000, 9'b10_0100_000));
    chk("add_k", K, 64'd0);
    drive(4'd4, 5'd30, 5'd1, 5'd5, 64'd0);
    chk("xor_cw", controlWord, mk(2'b01, 5'd30, 5'd1, 5'd5, 5'b01100, 9'b10_0100_000));
    chk("xor_done", done, 1'b1);
    drive(4'd5, 5'd17, 5'd30, 5'd0, 64'd2);
    chk("lsli_cw", controlWord, mk(2'b01, 5'd17, 5'd30, 5'd31, 5'b10000, 9'b10_0100_100));
    chk("lsli_k", K, 64'd2);
    chk("b2b_retired", retired, 16'd3);
    go_idle();

    // ADDI
    drive(4'd3, 5'd9, 5'd2, 5'd4, 64'hDEAD);
    chk("addi_cw", controlWord, mk(2'b01, 5'd9, 5'd2, 5'd31, 5'b01000, 9'b10_0100_100));
    chk("addi_k", K, 64'hDEAD);
    go_idle();

    // STUR rd=17 rn=7 imm=0
    drive(4'd6, 5'd17, 5'd7, 5'd0, 64'd0);
    chk("stur_cw", controlWord, mk(2'b01, 5'd31, 5'd7, 5'd17, 5'b01000, 9'b01_0010_100));
    chk("stur_done", done, 1'b1);
    go_idle();
    chk("stur_one_cycle", controlWord, NOPW);

    // LDUR rd=0 rn=7 imm=16: MEM_A then MEM_B; a pending command waits during MEM_A
    drive(4'd7, 5'd0, 5'd7, 5'd0, 64'd16);
    chk("ldur_a_cw", controlWord, mk(2'b00, 5'd31, 5'd7, 5'd31, 5'b01000, 9'b00_1000_100));
    chk("ldur_a_done", done, 1'b0);
    chk("ldur_a_k", K, 64'd16);
    @(negedge clock);
    cmd_op = 4'd1; cmd_rd = 5'd3; cmd_imm = 64'd5;
    #1 chk("ldur_a_ready", cmd_ready, 1'b0);
    @(posedge clock); #1;
    chk("ldur_b_cw", controlWord, mk(2'b01, 5'd0, 5'd7, 5'd31, 5'b01000, 9'b10_1000_100));
    chk("ldur_b_done", done, 1'b1);
    chk("ldur_b_k", K, 64'd16);
    @(negedge clock);
    #1 chk("ldur_b_ready", cmd_ready, 1'b1);
    @(posedge clock); #1;
    chk("after_ldur_movi", controlWord, mk(2'b01, 5'd3, 5'd31, 5'd31, 5'b00100, 9'b10_0100_100));
    chk("after_ldur_k", K, 64'd5);
    go_idle();

    // Illegal opcode
    do_reset();
    drive(4'd12, 5'd4, 5'd4, 5'd4, 64'd77);
    chk("ill_cw", controlWord, NOPW);
    chk("ill_err", err, 1'b1);
    chk("ill_done", done, 1'b0);
    chk("ill_retired", retired, 16'd0);
    chk("ill_k", K, 64'd0);
    go_idle();
    chk("ill_err_hold", err, 1'b1);
    do_reset();
    @(posedge clock); #1;
    chk("ill_err_cleared", err, 1'b0);

    // NOP op retires with PS=01
    drive(4'd0, 5'd1, 5'd2, 5'd3, 64'd9);
    chk("nop_cw", controlWord, NOPR);
    chk("nop_done", done, 1'b1);
    chk("nop_k", K, 64'd0);
    go_idle();

    // Retired-count wrap
    do_reset();
    cmd_valid = 1'b1; cmd_op = 4'd0;
    repeat (65535) @(posedge clock);
    #1 chk("ret_ffff", retired, 16'hFFFF);
    @(posedge clock); #1;
    chk("ret_wrap", retired, 16'h0000);
    chk("ret_wrap_done", done, 1'b1);
    go_idle();

    // Reset during LDUR MEM_A abandons it
    drive(4'd7, 5'd2, 5'd7, 5'd0, 64'd8);
    chk("ldur_a2_en_mem", controlWord[6], 1'b1);
    @(negedge clock);
    reset = 1'b1; cmd_valid = 1'b0;
    @(posedge clock); #1;
    chk("abort_cw", controlWord, NOPW);
    chk("abort_done", done, 1'b0);
    chk("abort_k", K, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_no_regw", controlWord, NOPW);
    chk("abort_no_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
